state_dump_unit: RTL and testbench
==================================

Name: state_dump_unit

Overview:
- Hardware producer of the per-cycle architectural snapshot the CPU bench prints: cycle count, PC, stall/flush counts, x0..x31 and the low data-memory words.
- Sits inside the CPU beside Registers and Data_Memory and uses one spare combinational read port on each.
- On request, streams one fixed-format frame out over a valid/ready word interface to an external collector (UART/JTAG bridge or bench monitor).

Parameters:
- NUM_DMEM_WORDS, 8: data-memory words dumped, from byte address 0x00 upward in steps of 4; range 1..32.
- FRAME_LEN, 35+NUM_DMEM_WORDS: words per frame; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  CPU run enable; gates all counters.
- snap_req_i  in  1  single-cycle snapshot request.
- pc_i  in  32  current PC.
- stall_i  in  1  load-use stall event this cycle.
- flush_i  in  1  IF/ID flush event this cycle.
- rf_addr_o  out  5  register-file read address.
- rf_data_i  in  32  register-file read data, combinational.
- dm_addr_o  out  32  data-memory byte address.
- dm_data_i  in  32  data-memory read data, combinational.
- dump_valid_o  out  1  output word valid.
- dump_data_o  out  32  output word.
- dump_last_o  out  1  final word of frame.
- dump_ready_i  in  1  collector ready.
- busy_o  out  1  frame in progress.
- freeze_o  out  1  hold request to the pipeline; equals busy_o.
- overrun_o  out  1  sticky: a request was dropped.

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs 0, rf_addr_o=0, dm_addr_o=0; counters 0; FSM goes to IDLE.
- Counters:
  - cyc_cnt is 32-bit, +1 per clock while start_i=1, wraps.
  - stall_cnt and flush_cnt are 16-bit, +1 per clock while start_i=1 and the event is high; they saturate at 0xFFFF.
- Frame word order, index k:
  - k=0: cyc_cnt.
  - k=1: PC.
  - k=2: {stall_cnt, flush_cnt}.
  - k=3..34: x0..x31.
  - k=35..35+NUM_DMEM_WORDS-1: dmem[0x00], dmem[0x04], ...
- Snapshot capture: words 0..2 use values captured at the edge the request is accepted, i.e. counter values before that edge's increment.
- Register and memory words are read live. freeze_o high lets the integration hold the pipeline so the frame is self-consistent.
- FSM has two states, IDLE and SEND.
  - IDLE: snap_req_i=1 at edge N → capture, load word 0 into the output register, k=0, enter SEND. dump_valid_o and busy_o are high in cycle N+1, giving 1-cycle latency.
  - SEND: dump_valid_o=1.
  - Fire = dump_valid_o & dump_ready_i. On fire, load word k+1 and increment k.
  - rf_addr_o and dm_addr_o always present the source of word k+1 during SEND, and 0 otherwise.
  - dm_addr_o = 4*(k+1-35).
  - dump_last_o = (k==FRAME_LEN-1) & dump_valid_o.
  - Fire on the last word → IDLE. dump_valid_o is low the next cycle unless a back-to-back request is taken (below).
- Stability: while dump_valid_o=1 and dump_ready_i=0, dump_data_o and dump_last_o hold; k does not advance.
- Simultaneous events:
  - snap_req_i in SEND is dropped and sets overrun_o, which stays set until reset.
  - Exception: snap_req_i in the same cycle as the last-word fire is accepted. The next frame's word 0 follows with no bubble, and overrun_o is not set.
- start_i falling mid-frame: the frame completes; counters freeze.
- Reset mid-frame: the frame is aborted immediately; no partial-frame recovery.
- Minimum frame duration: FRAME_LEN cycles with dump_ready_i tied high.

Decomposition:
- Shared package dump_pkg holds:
  - word-index constants: IDX_CYC=0, IDX_PC=1, IDX_EVT=2, IDX_REG0=3, IDX_DMEM0=35.
  - the FSM state enum {IDLE, SEND}.
  - REG_COUNT=32.
- Sub-module dump_event_counters holds the three counters with the start_i gating and saturation.
- The FSM, word mux and handshake stay in the top module.

Test Plan:
- Basic frame, ready always 1: reset, start_i=1; registers x1=7, x31=0xDEADBEEF; dmem[0]=5; snap_req_i at cycle 10. Expect 43 consecutive valid words: word0=10, word4=7, word34=0xDEADBEEF, word35=5. dump_last_o high only on word42; freeze_o high for exactly 43 cycles.
- Backpressure: dump_ready_i toggles 1,0,0,1 repeating. Data and last hold while ready=0, no word is skipped or duplicated, and the frame takes 86 cycles.
- Overrun and back-to-back:
  - snap_req_i at frame word 5 → request ignored; overrun_o=1 and stays set.
  - snap_req_i coincident with the last-word fire → the next frame's word0 appears in the following cycle; overrun_o unchanged.
- Counters: 3 stall pulses and 2 flush pulses with start_i=1, plus 4 stall pulses with start_i=0 → word2=0x00030002.
  - Force stall_cnt=0xFFFE, apply 5 pulses → field reads 0xFFFF.
- Async reset mid-frame: drop rst_i at word 20, off-edge → dump_valid_o, busy_o and overrun_o go to 0 before the next clock. After release, a new request yields word0 = cycles counted since release.
- Parameter sweep: NUM_DMEM_WORDS=1 → 36-word frame, last word = dmem[0x00]. NUM_DMEM_WORDS=32 → 67 words, last dm_addr_o=0x7C.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared frame layout constants and FSM state type for the architectural state dump unit.
package dump_pkg;

  localparam int IDX_CYC   = 0;
  localparam int IDX_PC    = 1;
  localparam int IDX_EVT   = 2;
  localparam int IDX_REG0  = 3;
  localparam int IDX_DMEM0 = 35;
  localparam int REG_COUNT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/dump_event_counters.sv
// Free-running cycle counter plus saturating stall/flush event counters, all gated by the CPU run enable.
module dump_event_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] cyc_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic event_hit);
    if (event_hit && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end
    return value;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (start) begin
      cyc_cnt   <= cyc_cnt + 32'd1;
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: rtl/state_dump_unit.sv
// Streams one fixed-format snapshot frame (counters, PC, x0..x31, low dmem words) over a
// valid/ready word port; register and memory words are fetched live through spare read ports.
module state_dump_unit
  import dump_pkg::*;
#(
  parameter int NUM_DMEM_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        snap_req_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [31:0] dm_addr_o,
  input  logic [31:0] dm_data_i,
  output logic        dump_valid_o,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  input  logic        dump_ready_i,
  output logic        busy_o,
  output logic        freeze_o,
  output logic        overrun_o
);

  localparam int FRAME_LEN = IDX_DMEM0 + NUM_DMEM_WORDS;
  localparam int KW        = $clog2(FRAME_LEN + 1);

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic [31:0]   cyc_cnt;
  logic [15:0]   stall_cnt, flush_cnt;
  logic [31:0]   snap_pc, snap_evt, load_word;
  logic          overrun;
  logic          fire, is_last, accept, advance, drop;
  int            src_idx;

  dump_event_counters u_cnt (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .start     (start_i),
    .stall     (stall_i),
    .flush     (flush_i),
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  assign dump_valid_o = (state == SEND);
  assign busy_o       = dump_valid_o;
  assign freeze_o     = busy_o;
  assign dump_last_o  = is_last & dump_valid_o;
  assign overrun_o    = overrun;

  // A request landing on the last-word fire starts the next frame without a bubble.
  always_comb begin
    fire      = dump_valid_o & dump_ready_i;
    is_last   = (int'(k) == FRAME_LEN - 1);
    accept    = snap_req_i & ((state == IDLE) | (fire & is_last));
    advance   = fire & ~is_last;
    drop      = snap_req_i & (state == SEND) & ~(fire & is_last);
    state_nxt = state;
    case (state)
      IDLE:    if (snap_req_i) state_nxt = SEND;
      SEND:    if (fire && is_last && !snap_req_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read ports always point at the source of the word that the next fire will load.
  always_comb begin
    src_idx   = int'(k) + 1;
    rf_addr_o = '0;
    dm_addr_o = '0;
    load_word = rf_data_i;
    if (state == SEND) begin
      if (src_idx >= IDX_REG0 && src_idx < IDX_REG0 + REG_COUNT) begin
        rf_addr_o = 5'(src_idx - IDX_REG0);
      end else if (src_idx >= IDX_DMEM0 && src_idx < FRAME_LEN) begin
        dm_addr_o = 32'(src_idx - IDX_DMEM0) << 2;
      end
    end
    if (src_idx == IDX_PC) begin
      load_word = snap_pc;
    end else if (src_idx == IDX_EVT) begin
      load_word = snap_evt;
    end else if (src_idx >= IDX_DMEM0) begin
      load_word = dm_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      k           <= '0;
      dump_data_o <= '0;
      overrun     <= 1'b0;
    end else begin
      if (accept) begin
        k           <= KW'(IDX_CYC);
        dump_data_o <= cyc_cnt;
      end else if (advance) begin
        k           <= k + 1'b1;
        dump_data_o <= load_word;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Snapshot of PC and event counters taken at the accepting edge; pure data, no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      snap_pc  <= pc_i;
      snap_evt <= {stall_cnt, flush_cnt};
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed/random bench for state_dump_unit: a word-queue frame model predicts every output cycle.
module tb_state_dump_unit;

  localparam int NDM   = 8;
  localparam int FRAME = 35 + NDM;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        snap_req = 1'b0;
  logic        snap_b = 1'b0;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        dump_ready = 1'b0;

  logic [4:0]  rf_addr;
  logic [31:0] rf_data, dm_addr, dm_data, dump_data;
  logic        dump_valid, dump_last, busy, freeze, overrun;

  logic [4:0]  s1_rf_addr, s32_rf_addr;
  logic [31:0] s1_rf_data, s32_rf_data, s1_dm_addr, s32_dm_addr, s1_dm_data, s32_dm_data;
  logic [31:0] s1_data, s32_data;
  logic        s1_valid, s1_last, s1_busy, s1_freeze, s1_ovr;
  logic        s32_valid, s32_last, s32_busy, s32_freeze, s32_ovr;

  logic [31:0] regs [32];
  logic [31:0] mem  [32];

  assign rf_data     = regs[rf_addr];
  assign dm_data     = mem[dm_addr[6:2]];
  assign s1_rf_data  = regs[s1_rf_addr];
  assign s1_dm_data  = mem[s1_dm_addr[6:2]];
  assign s32_rf_data = regs[s32_rf_addr];
  assign s32_dm_data = mem[s32_dm_addr[6:2]];

  always #5 clk = ~clk;

  state_dump_unit #(.NUM_DMEM_WORDS(NDM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .snap_req_i(snap_req), .pc_i(pc),
    .stall_i(stall), .flush_i(flush), .rf_addr_o(rf_addr), .rf_data_i(rf_data),
    .dm_addr_o(dm_addr), .dm_data_i(dm_data), .dump_valid_o(dump_valid),
    .dump_data_o(dump_data), .dump_last_o(dump_last), .dump_ready_i(dump_ready),
    .busy_o(busy), .freeze_o(freeze), .overrun_o(overrun)
  );

  state_dump_unit #(.NUM_DMEM_WORDS(1)) dut_s1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .snap_req_i(snap_b), .pc_i(pc),
    .stall_i(stall), .flush_i(flush), .rf_addr_o(s1_rf_addr), .rf_data_i(s1_rf_data),
    .dm_addr_o(s1_dm_addr), .dm_data_i(s1_dm_data), .dump_valid_o(s1_valid),
    .dump_data_o(s1_data), .dump_last_o(s1_last), .dump_ready_i(1'b1),
    .busy_o(s1_busy), .freeze_o(s1_freeze), .overrun_o(s1_ovr)
  );

  state_dump_unit #(.NUM_DMEM_WORDS(32)) dut_s32 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .snap_req_i(snap_b), .pc_i(pc),
    .stall_i(stall), .flush_i(flush), .rf_addr_o(s32_rf_addr), .rf_data_i(s32_rf_data),
    .dm_addr_o(s32_dm_addr), .dm_data_i(s32_dm_data), .dump_valid_o(s32_valid),
    .dump_data_o(s32_data), .dump_last_o(s32_last), .dump_ready_i(1'b1),
    .busy_o(s32_busy), .freeze_o(s32_freeze), .overrun_o(s32_ovr)
  );

  int          total = 0;
  int          bad = 0;
  int          vcount = 0;
  int          lcount = 0;
  bit          rnd_evt = 1'b0;
  logic [31:0] m_cyc;
  logic [15:0] m_stall, m_flush;
  logic        m_ovr;
  logic [31:0] m_q [$];
  logic [31:0] got [64];
  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    m_q.push_back(m_cyc);
    m_q.push_back(pc);
    m_q.push_back({m_stall, m_flush});
    for (int r = 0; r < 32; r++) m_q.push_back(regs[r]);
    for (int d = 0; d < NDM; d++) m_q.push_back(mem[d]);
  endtask

  // Called at a falling edge: drive, check the visible state, advance the model over the next rising edge.
  task automatic cycle(input logic rdy, input logic req);
    int k, nxt, exp_rf, exp_dm;
    logic act;
    dump_ready = rdy;
    snap_req   = req;
    pc         = $urandom;
    if (rnd_evt) begin
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 3) == 0);
    end
    act = (m_q.size() != 0);
    chk("valid", 32'(dump_valid), 32'(act));
    chk("busy", 32'(busy), 32'(act));
    chk("freeze", 32'(freeze), 32'(act));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("last", 32'(dump_last), 32'(act && m_q.size() == 1));
    k = FRAME - m_q.size();
    nxt = k + 1;
    exp_rf = 0;
    exp_dm = 0;
    if (act) begin
      vcount++;
      if (dump_last) lcount++;
      chk("data", dump_data, m_q[0]);
      if (nxt >= 3 && nxt < 35) exp_rf = nxt - 3;
      else if (nxt >= 35 && nxt < FRAME) exp_dm = 4 * (nxt - 35);
    end
    chk("rf_addr", 32'(rf_addr), 32'(exp_rf));
    chk("dm_addr", dm_addr, 32'(exp_dm));
    if (act && rdy) begin
      got[k] = dump_data;
      void'(m_q.pop_front());
    end
    if (req) begin
      if (m_q.size() == 0) push_frame();
      else m_ovr = 1'b1;
    end
    if (start) begin
      m_cyc++;
      if (stall && m_stall != 16'hFFFF) m_stall++;
      if (flush && m_flush != 16'hFFFF) m_flush++;
    end
    @(negedge clk);
  endtask

  // mode 0: ready high, 1: 1,0,0,1 pattern from phase t0, 2: random. req_k: word index to request on.
  task automatic run_frame(input int mode, input int t0, input int req_k);
    bit   sent = 1'b0;
    int   i = 0;
    logic rdy, rq;
    while (m_q.size() != 0 && i < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[(t0 + i) % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rq = 1'b0;
      if (!sent && (FRAME - m_q.size()) == req_k) begin
        rq = 1'b1;
        sent = 1'b1;
      end
      cycle(rdy, rq);
      i++;
    end
    chk("frame_done", 32'(m_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    m_q.delete();
    m_cyc = '0;
    m_stall = '0;
    m_flush = '0;
    m_ovr = 1'b0;
    #1;
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_last", 32'(dump_last), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
  endtask

  initial begin
    int guard, c1, c32, lc1;
    logic [31:0] w1, w32, max_dm;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    for (int d = 0; d < 32; d++) mem[d] = $urandom;
    regs[0] = '0;

    // Reset, then basic frame with ready held high
    #3;
    apply_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    rnd_evt = 1'b1;
    regs[1] = 32'd7;
    regs[31] = 32'hDEADBEEF;
    mem[0] = 32'd5;
    repeat (10) cycle(1'b1, 1'b0);
    vcount = 0;
    lcount = 0;
    cycle(1'b1, 1'b1);
    run_frame(0, 0, -1);
    chk("f1_cycles", 32'(vcount), 32'd43);
    chk("f1_last_cnt", 32'(lcount), 32'd1);
    chk("f1_word0", got[0], 32'd10);
    chk("f1_word4", got[4], 32'd7);
    chk("f1_word34", got[34], 32'hDEADBEEF);
    chk("f1_word35", got[35], 32'd5);
    repeat (3) cycle(1'b1, 1'b0);

    // Backpressure with ready pattern 1,0,0,1
    for (int r = 1; r < 32; r++) regs[r] = $urandom;
    for (int d = 0; d < NDM; d++) mem[d] = $urandom;
    vcount = 0;
    cycle(1'b0, 1'b1);
    run_frame(1, 2, -1);
    chk("bp_cycles", 32'(vcount), 32'd86);
    repeat (2) cycle(1'b1, 1'b0);

    // Back-to-back: request coincident with the last-word fire
    vcount = 0;
    cycle(1'b1, 1'b1);
    run_frame(0, 0, FRAME - 1);
    chk("b2b_cycles", 32'(vcount), 32'd86);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    repeat (2) cycle(1'b1, 1'b0);

    // Overrun: request while word 5 is presented, random ready
    cycle(1'b1, 1'b1);
    run_frame(2, 0, 5);
    repeat (3) cycle(1'b1, 1'b0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-frame at word 20
    cycle(1'b1, 1'b1);
    guard = 0;
    while ((FRAME - m_q.size()) < 20 && guard < 100) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    chk("reach_word20", 32'(FRAME - m_q.size()), 32'd20);
    #2;
    apply_reset();
    @(negedge clk);
    rst = 1'b1;

    // Counters after release: gated stalls, then 3 stalls and 2 flushes while running
    rnd_evt = 1'b0;
    start = 1'b0;
    stall = 1'b1;
    flush = 1'b0;
    repeat (4) cycle(1'b1, 1'b0);
    start = 1'b1;
    repeat (3) cycle(1'b1, 1'b0);
    stall = 1'b0;
    flush = 1'b1;
    repeat (2) cycle(1'b1, 1'b0);
    flush = 1'b0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    run_frame(0, 0, -1);
    chk("cnt_word0", got[0], 32'd6);
    chk("cnt_word2", got[2], 32'h00030002);

    // Stall counter saturation
    stall = 1'b1;
    repeat (65540) cycle(1'b1, 1'b0);
    stall = 1'b0;
    cycle(1'b1, 1'b1);
    run_frame(0, 0, -1);
    chk("sat_stall", 32'(got[2][31:16]), 32'h0000FFFF);
    chk("sat_flush", 32'(got[2][15:0]), 32'd2);

    // Parameter sweep: 1 and 32 dmem words
    rnd_evt = 1'b1;
    c1 = 0; c32 = 0; lc1 = 0;
    w1 = '0; w32 = '0; max_dm = '0;
    snap_b = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 0) snap_b = 1'b0;
      if (s1_valid) begin
        c1++;
        w1 = s1_data;
        if (s1_last) lc1++;
      end
      if (s32_valid) begin
        c32++;
        w32 = s32_data;
        if (s32_dm_addr > max_dm) max_dm = s32_dm_addr;
      end
    end
    chk("s1_len", 32'(c1), 32'd36);
    chk("s1_last_cnt", 32'(lc1), 32'd1);
    chk("s1_last_word", w1, mem[0]);
    chk("s32_len", 32'(c32), 32'd67);
    chk("s32_last_word", w32, mem[31]);
    chk("s32_max_dm_addr", max_dm, 32'h7C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
